// File: rtl/random_range_gen.sv
// random_range_gen: free-running Galois LFSR drawing a value in [MIN_VAL,MAX_VAL] per req/ack handshake.
// Optional RND_SEED_LOAD_EN adds seed_load/seed_in for runtime reseeding.
module random_range_gen #(
  parameter int WIDTH = 14,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(14'h2015),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(14'h3FFF),
  parameter logic [WIDTH-1:0] MIN_VAL = WIDTH'(1000),
  parameter logic [WIDTH-1:0] MAX_VAL = WIDTH'(5000),
  parameter int MAX_TRIES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             ack,
`ifdef RND_SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
`endif
  output logic [WIDTH-1:0] random,
  output logic             rnd_ready,
  output logic             rnd_busy,
  output logic             rnd_timeout
);
  localparam int CW = $clog2(MAX_TRIES + 1);
  typedef enum logic [1:0] {IDLE, SEARCH, READY} state_t;
  state_t state;
  logic [WIDTH-1:0] lfsr, lfsr_nxt, shift;
  logic [CW-1:0] try_cnt;
  logic hit;
  always_comb begin
    shift = lfsr[0] ? (lfsr >> 1) ^ TAPS : lfsr >> 1;
`ifdef RND_SEED_LOAD_EN
    lfsr_nxt = seed_load ? (seed_in == '0 ? SEED : seed_in) : (lfsr == '0 ? SEED : shift);
`else
    lfsr_nxt = lfsr == '0 ? SEED : shift;
`endif
    hit = lfsr >= MIN_VAL && lfsr <= MAX_VAL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= SEED;
      random      <= '0;
      rnd_timeout <= 1'b0;
      try_cnt     <= '0;
      state       <= IDLE;
    end else begin
      lfsr <= lfsr_nxt;
      case (state)
        IDLE: if (req) begin
          state       <= SEARCH;
          try_cnt     <= '0;
          rnd_timeout <= 1'b0;
        end
        SEARCH: if (hit) begin
          random <= lfsr;
          state  <= READY;
        end else if (try_cnt == CW'(MAX_TRIES - 1)) begin
          rnd_timeout <= 1'b1;
          state       <= IDLE;
        end else
          try_cnt <= try_cnt + 1'b1;
        READY: if (req) begin
          state   <= SEARCH;
          try_cnt <= '0;
        end else if (ack)
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign rnd_busy  = state == SEARCH;
  assign rnd_ready = state == READY;
endmodule

// File: tb/tb_random_range_gen.sv
// tb_random_range_gen: scoreboarded draws against a reference LFSR plus directed reset/range/timeout cases.
module tb_random_range_gen;
  localparam logic [13:0] SEED = 14'h3FFF, TAPS = 14'h2015, LO = 14'd1000, HI = 14'd5000;
  localparam int MT = 1024;
  logic clk = 0, reset = 1;
  logic req_d = 0, ack_d = 0, req_h = 0, ack_h = 0, req_t = 0, ack_t = 0;
  logic seed_load = 0;
  logic [13:0] seed_in = '0;
  logic [13:0] random_d, random_h, random_t;
  logic ready_d, busy_d, to_d, ready_h, busy_h, to_h, ready_t, busy_t, to_t;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  random_range_gen u_def (
    .clk(clk), .reset(reset), .req(req_d), .ack(ack_d),
`ifdef RND_SEED_LOAD_EN
    .seed_load(seed_load), .seed_in(seed_in),
`endif
    .random(random_d), .rnd_ready(ready_d), .rnd_busy(busy_d), .rnd_timeout(to_d));
  random_range_gen #(.MIN_VAL(14'h3000), .MAX_VAL(14'h3FFF)) u_hi (
    .clk(clk), .reset(reset), .req(req_h), .ack(ack_h),
`ifdef RND_SEED_LOAD_EN
    .seed_load(1'b0), .seed_in(14'h0),
`endif
    .random(random_h), .rnd_ready(ready_h), .rnd_busy(busy_h), .rnd_timeout(to_h));
  random_range_gen #(.MIN_VAL(14'h0), .MAX_VAL(14'h0), .MAX_TRIES(8)) u_to (
    .clk(clk), .reset(reset), .req(req_t), .ack(ack_t),
`ifdef RND_SEED_LOAD_EN
    .seed_load(1'b0), .seed_in(14'h0),
`endif
    .random(random_t), .rnd_ready(ready_t), .rnd_busy(busy_t), .rnd_timeout(to_t));
  function automatic logic [13:0] step(input logic [13:0] v);
    return v == '0 ? SEED : (v[0] ? (v >> 1) ^ TAPS : v >> 1);
  endfunction
  logic [13:0] m_lfsr;
  always @(posedge clk)
    if (reset) m_lfsr <= SEED;
`ifdef RND_SEED_LOAD_EN
    else if (seed_load) m_lfsr <= seed_in == '0 ? SEED : seed_in;
`endif
    else m_lfsr <= step(m_lfsr);
  typedef struct {bit to; logic [13:0] val; int lat;} exp_t;
  exp_t sbq[$];
  logic [13:0] last_val = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp();
    logic [13:0] cur = step(m_lfsr);
    for (int t = 0; t < MT; t++) begin
      if (cur >= LO && cur <= HI) begin
        sbq.push_back('{1'b0, cur, t + 1});
        return;
      end
      cur = step(cur);
    end
    sbq.push_back('{1'b1, last_val, MT});
  endtask
  task automatic draw(input bit do_ack);
    exp_t e;
    int n = 0;
    push_exp();
    req_d = 1;
    tick();
    req_d = 0;
    chk("busy", 32'(busy_d), 1);
    while (!ready_d && !to_d && n < MT + 4) begin
      tick();
      n++;
    end
    e = sbq.pop_front();
    chk("latency", n, e.lat);
    chk("timeout", 32'(to_d), 32'(e.to));
    chk("random", 32'(random_d), 32'(e.val));
    if (!e.to) begin
      chk("in_range", 32'(random_d >= LO && random_d <= HI), 1);
      last_val = e.val;
    end
    if (do_ack) begin
      ack_d = 1;
      tick();
      ack_d = 0;
      chk("ack_clr", 32'(ready_d), 0);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_random"}, 32'(random_d), 0);
    chk({tag, "_ready"}, 32'(ready_d), 0);
    chk({tag, "_busy"}, 32'(busy_d), 0);
    chk({tag, "_timeout"}, 32'(to_d), 0);
    chk({tag, "_lfsr"}, 32'(u_def.lfsr), 32'(SEED));
  endtask
  initial begin
    int cnt;
    tick();
    tick();
    chk_reset("rst");
    reset = 0;
    req_h = 1;
    tick();
    req_h = 0;
    chk("lfsr1", 32'(u_def.lfsr), 32'h3FEA);
    chk("hi_busy", 32'(busy_h), 1);
    tick();
    chk("lfsr2", 32'(u_def.lfsr), 32'h1FF5);
    chk("hi_ready", 32'(ready_h), 1);
    chk("hi_random", 32'(random_h), 32'h3FEA);
    ack_h = 1;
    tick();
    ack_h = 0;
    chk("lfsr3", 32'(u_def.lfsr), 32'h2FEF);
    chk("hi_ack", 32'(ready_h), 0);
    req_t = 1;
    tick();
    req_t = 0;
    cnt = 0;
    while (busy_t && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("to_busy_cycles", cnt, 8);
    chk("to_flag", 32'(to_t), 1);
    chk("to_ready", 32'(ready_t), 0);
    chk("to_random", 32'(random_t), 0);
    req_t = 1;
    tick();
    req_t = 0;
    chk("to_cleared", 32'(to_t), 0);
    chk("to_rebusy", 32'(busy_t), 1);
    for (int i = 0; i < 1000; i++) draw(1);
    draw(0);
    req_d = 1;
    ack_d = 1;
    tick();
    req_d = 0;
    ack_d = 0;
    chk("reqack_ready", 32'(ready_d), 0);
    chk("reqack_busy", 32'(busy_d), 1);
    reset = 1;
    tick();
    reset = 0;
    last_val = '0;
    chk_reset("midrst");
`ifdef RND_SEED_LOAD_EN
    seed_load = 1;
    seed_in = '0;
    tick();
    chk("seed_zero", 32'(u_def.lfsr), 32'(SEED));
    seed_in = 14'h0001;
    tick();
    seed_load = 0;
    chk("seed_one", 32'(u_def.lfsr), 32'h0001);
    tick();
    chk("seed_shift", 32'(u_def.lfsr), 32'h2015);
`endif
    for (int i = 0; i < 5; i++) draw(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
